// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the OV7670 capture path.
//   - Capture FSM state encoding (IDLE=0, ARMED=1, CAPTURE=2, DONE=3).
//   - Default frame geometry and counter width. The pixel-packing datapath
//     and the display side use the same geometry constants.
package cam_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } cap_state_t;

   localparam int H_PIX_DEF    = 160;  // RGB332 pixels per line
   localparam int V_LINES_DEF  = 120;  // lines per frame
   localparam int CW_DEF       = 8;    // line/pixel counter width
   localparam int BYTES_PER_PX = 2;    // camera bytes per packed pixel
   localparam int LINE_BYTES   = H_PIX_DEF * BYTES_PER_PX;
   localparam int FRAME_PIX    = H_PIX_DEF * V_LINES_DEF;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and rising-edge pulse.
//   pclk  in  : sampling clock
//   rst   in  : asynchronous active-low reset
//   btn   in  : raw, asynchronous button level (active-high)
//   rise  out : one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level only follows the synchronised input after DEB_CYC
// consecutive samples that differ from the current level.
module btn_debounce #(
   parameter int DEB_CYC = 16
) (
   input  logic pclk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   localparam int DW = $clog2(DEB_CYC + 1);

   logic          s1, s2;
   logic          level;
   logic [DW-1:0] cnt;

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         rise <= 1'b0;
         if (s2 == level) begin
            // any sample agreeing with the current level restarts the run
            cnt <= '0;
         end else if (cnt == DW'(DEB_CYC - 1)) begin
            cnt   <= '0;
            level <= s2;
            rise  <= s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-capture controller in the camera pclk domain.
//   pclk, rst      : clock, asynchronous active-low reset
//   vsync, href    : camera sync inputs (vsync high between frames)
//   btnP           : raw snapshot button
//   mode_cont      : 1 = continuous, 0 = snapshot (sampled in IDLE/DONE)
//   cap_en         : datapath write gate, high in CAPTURE
//   frame_start    : pulse on entering CAPTURE
//   frame_done     : pulse in DONE
//   frame_err      : error status of last completed frame
//   buf_sel        : buffer being written; display reads ~buf_sel
//   busy           : high in ARMED and CAPTURE
//   line_cnt       : lines completed in current/last frame
//   px_cnt         : pixels completed in current line
module cam_capture_ctrl
   import cam_pkg::*;
#(
   parameter int H_PIX   = H_PIX_DEF,
   parameter int V_LINES = V_LINES_DEF,
   parameter int DEB_CYC = 16,
   parameter int CW      = CW_DEF
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          href,
   input  logic          btnP,
   input  logic          mode_cont,
   output logic          cap_en,
   output logic          frame_start,
   output logic          frame_done,
   output logic          frame_err,
   output logic          buf_sel,
   output logic          busy,
   output logic [CW-1:0] line_cnt,
   output logic [CW-1:0] px_cnt
);

   localparam logic [CW-1:0] H_PIX_C   = CW'(H_PIX);
   localparam logic [CW-1:0] V_LINES_C = CW'(V_LINES);

   cap_state_t    state, state_nxt;
   logic          snap_req;
   logic          vsync_d, href_d;
   logic          vs_fall, vs_rise, hr_fall;
   logic          phase, phase_nxt;
   logic          err, err_nxt;
   logic [CW-1:0] px_nxt, line_nxt;
   logic          start_now, done_now;

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .pclk (pclk),
      .rst  (rst),
      .btn  (btnP),
      .rise (snap_req)
   );

   assign vs_fall = vsync_d & ~vsync;
   assign vs_rise = ~vsync_d & vsync;
   assign hr_fall = href_d & ~href;

   assign start_now = (state == S_ARMED)   && vs_fall;
   assign done_now  = (state == S_CAPTURE) && vs_rise;

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (mode_cont || snap_req) state_nxt = S_ARMED;
         S_ARMED:   if (vs_fall) state_nxt = S_CAPTURE;
         S_CAPTURE: if (vs_rise) state_nxt = S_DONE;
         S_DONE:    state_nxt = mode_cont ? S_ARMED : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // frame/line bookkeeping; err_nxt already includes the end-of-frame
   // checks so DONE can latch it directly
   always_comb begin
      phase_nxt = phase;
      px_nxt    = px_cnt;
      line_nxt  = line_cnt;
      err_nxt   = err;
      if (start_now) begin
         phase_nxt = 1'b0;
         px_nxt    = '0;
         line_nxt  = '0;
         err_nxt   = 1'b0;
      end else if (state == S_CAPTURE) begin
         if (href) begin
            phase_nxt = ~phase;
            if (phase && (px_cnt != '1)) px_nxt = px_cnt + 1'b1;
         end
         if (hr_fall) begin
            if (line_cnt != '1) line_nxt = line_cnt + 1'b1;
            px_nxt    = '0;
            phase_nxt = 1'b0;
            if ((px_cnt != H_PIX_C) || phase) err_nxt = 1'b1;
         end
         if (vs_rise) begin
            // a line still open at vsync rise is dropped and flags the frame
            if (href) err_nxt = 1'b1;
            if (line_nxt != V_LINES_C) err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         vsync_d     <= 1'b0;
         href_d      <= 1'b0;
         phase       <= 1'b0;
         err         <= 1'b0;
         px_cnt      <= '0;
         line_cnt    <= '0;
         cap_en      <= 1'b0;
         busy        <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         buf_sel     <= 1'b0;
      end else begin
         state       <= state_nxt;
         vsync_d     <= vsync;
         href_d      <= href;
         phase       <= phase_nxt;
         err         <= err_nxt;
         px_cnt      <= px_nxt;
         line_cnt    <= line_nxt;
         cap_en      <= (state_nxt == S_CAPTURE);
         busy        <= (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
         frame_start <= start_now;
         frame_done  <= done_now;
         if (done_now) begin
            frame_err <= err_nxt;
            // only a clean frame is handed to the display
            if (!err_nxt) buf_sel <= ~buf_sel;
         end
      end
   end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl with reduced frame geometry
// (10 pixels x 12 lines) so many frames fit in a short run.
module tb_cam_capture_ctrl;

   localparam int H  = 10;
   localparam int V  = 12;
   localparam int CW = 8;

   logic          pclk = 1'b0;
   logic          rst, vsync, href, btnP, mode_cont;
   logic          cap_en, frame_start, frame_done, frame_err, buf_sel, busy;
   logic [CW-1:0] line_cnt, px_cnt;

   typedef struct packed {
      logic          err;
      logic          bsel;
      logic [CW-1:0] lines;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_pass = 0;
   int   snap_cnt = 0, fs_cnt = 0, capen_cnt = 0, busy_low = 0, done_cnt = 0;

   cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .DEB_CYC(16), .CW(CW)) dut (
      .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .btnP(btnP),
      .mode_cont(mode_cont), .cap_en(cap_en), .frame_start(frame_start),
      .frame_done(frame_done), .frame_err(frame_err), .buf_sel(buf_sel),
      .busy(busy), .line_cnt(line_cnt), .px_cnt(px_cnt)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic push(input logic e, input logic b, input int l);
      exp_t x;
      x.err = e; x.bsel = b; x.lines = CW'(l);
      q.push_back(x);
   endtask

   // One frame: vsync high gap, then lines of 2*H bytes. short_ln gets
   // short_b bytes; at abort_ln vsync rises mid-line; drop_mode clears
   // mode_cont after line 3.
   task automatic frame(input int short_ln, input int short_b,
                        input int abort_ln, input bit drop_mode);
      int nb;
      vsync = 1'b1; repeat (4) tick();
      vsync = 1'b0; repeat (3) tick();
      for (int l = 0; l < V; l++) begin
         if (l == abort_ln) begin
            href = 1'b1; repeat (7) tick();
            vsync = 1'b1; tick();
            href = 1'b0; repeat (3) tick();
            return;
         end
         nb = (l == short_ln) ? short_b : 2 * H;
         href = 1'b1; repeat (nb) tick();
         href = 1'b0; repeat (4) tick();
         if (drop_mode && l == 3) mode_cont = 1'b0;
      end
      vsync = 1'b1; repeat (4) tick();
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (dut.snap_req) snap_cnt++;
         if (frame_start) fs_cnt++;
         if (cap_en) capen_cnt++;
         if (!busy) busy_low++;
         if (frame_start) chk("start_with_cap_en", int'(cap_en), 1);
         if (frame_done) begin
            done_cnt++;
            chk("done_busy_low", int'(busy), 0);
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               chk("done_frame_err", int'(frame_err), int'(e.err));
               chk("done_buf_sel", int'(buf_sel), int'(e.bsel));
               chk("done_line_cnt", int'(line_cnt), int'(e.lines));
            end
         end
      end
   end

   initial begin
      int s0;
      rst = 1'b0; vsync = 1'b1; href = 1'b0; btnP = 1'b0; mode_cont = 1'b0;
      repeat (3) tick();
      chk("rst_cap_en", int'(cap_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_buf_sel", int'(buf_sel), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_line_cnt", int'(line_cnt), 0);
      rst = 1'b1;
      repeat (3) tick();
      chk("idle_busy", int'(busy), 0);
      chk("idle_px_cnt", int'(px_cnt), 0);

      // snapshot, good frame
      btnP = 1'b1; repeat (40) tick(); btnP = 1'b0;
      chk("snap_pulses", snap_cnt, 1);
      chk("armed_busy", int'(busy), 1);
      push(1'b0, 1'b1, V);
      frame(-1, 0, -1, 1'b0);
      repeat (3) tick();
      chk("snap_back_idle", int'(busy), 0);
      capen_cnt = 0;
      frame(-1, 0, -1, 1'b0);
      chk("idle_frame_no_cap", capen_cnt, 0);
      chk("snap_one_start", fs_cnt, 1);

      // bounce then stable high -> one request; short glitch -> none
      s0 = snap_cnt;
      for (int i = 0; i < 10; i++) begin
         btnP = ~btnP; repeat (3) tick();
      end
      btnP = 1'b1; repeat (30) tick();
      btnP = 1'b0; repeat (30) tick();
      chk("bounce_pulses", snap_cnt - s0, 1);
      s0 = snap_cnt;
      btnP = 1'b1; repeat (10) tick();
      btnP = 1'b0; repeat (30) tick();
      chk("glitch_pulses", snap_cnt - s0, 0);
      push(1'b0, 1'b0, V);
      frame(-1, 0, -1, 1'b0);

      // continuous: three good frames
      mode_cont = 1'b1; repeat (3) tick();
      busy_low = 0;
      push(1'b0, 1'b1, V); frame(-1, 0, -1, 1'b0);
      push(1'b0, 1'b0, V); frame(-1, 0, -1, 1'b0);
      push(1'b0, 1'b1, V); frame(-1, 0, -1, 1'b0);
      chk("cont_busy_low_cycles", busy_low, 3);

      // short line 5, then a good frame clears the error
      push(1'b1, 1'b1, V); frame(5, 2 * H - 2, -1, 1'b0);
      push(1'b0, 1'b0, V); frame(-1, 0, -1, 1'b0);
      // vsync rises mid-line after 6 complete lines
      push(1'b1, 1'b0, 6); frame(-1, 0, 6, 1'b0);
      // mode_cont drops mid-frame: frame completes, then IDLE
      push(1'b0, 1'b1, V); frame(-1, 0, -1, 1'b1);
      repeat (3) tick();
      chk("drop_mode_idle", int'(busy), 0);

      // reset mid-capture
      mode_cont = 1'b1; repeat (3) tick();
      vsync = 1'b1; repeat (4) tick();
      vsync = 1'b0; repeat (3) tick();
      href = 1'b1; repeat (5) tick();
      chk("pre_rst_cap_en", int'(cap_en), 1);
      #2 rst = 1'b0;
      #1 chk("async_rst_cap_en", int'(cap_en), 0);
      chk("async_rst_buf_sel", int'(buf_sel), 0);
      mode_cont = 1'b0; href = 1'b0; vsync = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("post_rst_busy", int'(busy), 0);
      capen_cnt = 0;
      frame(-1, 0, -1, 1'b0);
      chk("post_rst_no_cap", capen_cnt, 0);
      repeat (5) tick();
      chk("done_total", done_cnt, 9);
      chk("queue_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
